// File: rtl/decode_ctl.sv
// decode_ctl: registered MIPS instruction decoder with valid/ready handshakes and a HI/LO interlock.
// Define DECODE_ALU_EXT_EN to give SLT/SLTI, SLTU/SLTIU and LUI dedicated ALU codes.
module decode_ctl #(
    parameter int MULDIV_LAT = 32,
    localparam int CNT_W = $clog2(MULDIV_LAT + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid_i,
    input  logic [31:0] instr_i,
    output logic        instr_ready_o,
    input  logic        flush_i,
    output logic        ctl_valid_o,
    input  logic        ctl_ready_i,
    output logic        reg_dst_ctl_o,
    output logic        jump_ctl_o,
    output logic        branch_ctl_o,
    output logic        mem_read_ctl_o,
    output logic        mem_to_reg_ctl_o,
    output logic [3:0]  alu_op_ctl_o,
    output logic        mem_wr_ctl_o,
    output logic        alu_src_ctl_o,
    output logic        reg_wr_ctl_o,
    output logic        link_ctl_o,
    output logic        illegal_ctl_o,
    output logic        muldiv_start_o,
    output logic        hilo_busy_o
);

    typedef struct packed {
        logic       reg_dst;
        logic       jump;
        logic       branch;
        logic       mem_read;
        logic       mem_to_reg;
        logic [3:0] alu_op;
        logic       mem_wr;
        logic       alu_src;
        logic       reg_wr;
        logic       link;
        logic       illegal;
    } ctl_t;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_SLL = 4'b0010;
    localparam logic [3:0] ALU_SRL = 4'b0011;
    localparam logic [3:0] ALU_SRA = 4'b0100;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_AND = 4'b0110;
    localparam logic [3:0] ALU_NOR = 4'b0111;
    localparam logic [3:0] ALU_XOR = 4'b1000;
`ifdef DECODE_ALU_EXT_EN
    localparam logic [3:0] ALU_SLT  = 4'b1001;
    localparam logic [3:0] ALU_SLTU = 4'b1010;
    localparam logic [3:0] ALU_LUI  = 4'b1011;
`else
    localparam logic [3:0] ALU_SLT  = ALU_SUB;
    localparam logic [3:0] ALU_SLTU = ALU_SUB;
    localparam logic [3:0] ALU_LUI  = ALU_ADD;
`endif

    // Busy cycles still to come after the current one; a dependent op is let through once it hits zero.
    localparam logic [CNT_W-1:0] BUSY_LOAD = CNT_W'(MULDIV_LAT - 1);

    logic [5:0] op;
    logic [4:0] rt;
    logic [5:0] funct;
    logic       unused_fields;
    ctl_t       dec;
    ctl_t       ctl_q;
    logic       dec_hilo;
    logic       dec_muldiv;
    logic       hazard;
    logic       accept;
    logic [CNT_W-1:0] busy_cnt;

    assign op            = instr_i[31:26];
    assign rt            = instr_i[20:16];
    assign funct         = instr_i[5:0];
    assign unused_fields = ^{instr_i[25:21], instr_i[15:6]};

    function automatic ctl_t r_alu(input logic [3:0] alu);
        ctl_t c;
        c         = '0;
        c.reg_dst = 1'b1;
        c.reg_wr  = 1'b1;
        c.alu_op  = alu;
        return c;
    endfunction

    function automatic ctl_t i_alu(input logic [3:0] alu);
        ctl_t c;
        c         = '0;
        c.alu_src = 1'b1;
        c.reg_wr  = 1'b1;
        c.alu_op  = alu;
        return c;
    endfunction

    function automatic ctl_t branch_c(input logic link);
        ctl_t c;
        c        = '0;
        c.branch = 1'b1;
        c.alu_op = ALU_SUB;
        c.reg_wr = link;
        c.link   = link;
        return c;
    endfunction

    always_comb begin
        dec        = '0;
        dec_hilo   = 1'b0;
        dec_muldiv = 1'b0;
        case (op)
            6'b000000: begin
                case (funct)
                    6'b000000, 6'b000100: dec = r_alu(ALU_SLL);
                    6'b000010, 6'b000110: dec = r_alu(ALU_SRL);
                    6'b000011, 6'b000111: dec = r_alu(ALU_SRA);
                    6'b100000, 6'b100001: dec = r_alu(ALU_ADD);
                    6'b100010, 6'b100011: dec = r_alu(ALU_SUB);
                    6'b100100:            dec = r_alu(ALU_AND);
                    6'b100101:            dec = r_alu(ALU_OR);
                    6'b100110:            dec = r_alu(ALU_XOR);
                    6'b100111:            dec = r_alu(ALU_NOR);
                    6'b101010:            dec = r_alu(ALU_SLT);
                    6'b101011:            dec = r_alu(ALU_SLTU);
                    6'b010000, 6'b010010: begin
                        dec      = r_alu(ALU_ADD);
                        dec_hilo = 1'b1;
                    end
                    6'b010001, 6'b010011: dec_hilo = 1'b1;
                    6'b011000, 6'b011001, 6'b011010, 6'b011011: begin
                        dec_hilo   = 1'b1;
                        dec_muldiv = 1'b1;
                    end
                    6'b001000: dec.jump = 1'b1;
                    6'b001001: begin
                        dec      = r_alu(ALU_ADD);
                        dec.jump = 1'b1;
                        dec.link = 1'b1;
                    end
                    6'b001100: dec = '0;
                    default:   dec.illegal = 1'b1;
                endcase
            end
            6'b000001: begin
                case (rt)
                    5'b00000, 5'b00001: dec = branch_c(1'b0);
                    5'b10000, 5'b10001: dec = branch_c(1'b1);
                    default:            dec.illegal = 1'b1;
                endcase
            end
            6'b000010: dec.jump = 1'b1;
            6'b000011: begin
                dec.jump   = 1'b1;
                dec.reg_wr = 1'b1;
                dec.link   = 1'b1;
            end
            6'b000100, 6'b000101, 6'b000110, 6'b000111: dec = branch_c(1'b0);
            6'b001000, 6'b001001: dec = i_alu(ALU_ADD);
            6'b001010:            dec = i_alu(ALU_SLT);
            6'b001011:            dec = i_alu(ALU_SLTU);
            6'b001100:            dec = i_alu(ALU_AND);
            6'b001101:            dec = i_alu(ALU_OR);
            6'b001110:            dec = i_alu(ALU_XOR);
            6'b001111:            dec = i_alu(ALU_LUI);
            6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101: begin
                dec            = i_alu(ALU_ADD);
                dec.mem_read   = 1'b1;
                dec.mem_to_reg = 1'b1;
            end
            6'b101000, 6'b101001, 6'b101011: begin
                dec.alu_src = 1'b1;
                dec.mem_wr  = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    assign hilo_busy_o   = (busy_cnt != '0);
    assign hazard        = hilo_busy_o && dec_hilo;
    assign instr_ready_o = !flush_i && !hazard && (!ctl_valid_o || ctl_ready_i);
    assign accept        = instr_valid_i && instr_ready_o;

    // Flush wins over consume; the bundle itself only changes on an accept so it holds while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctl_valid_o    <= 1'b0;
            ctl_q          <= '0;
            muldiv_start_o <= 1'b0;
            busy_cnt       <= '0;
        end else begin
            muldiv_start_o <= accept && dec_muldiv;
            if (accept && dec_muldiv) begin
                busy_cnt <= BUSY_LOAD;
            end else if (busy_cnt != '0) begin
                busy_cnt <= busy_cnt - 1'b1;
            end
            if (flush_i) begin
                ctl_valid_o <= 1'b0;
            end else if (accept) begin
                ctl_valid_o <= 1'b1;
            end else if (ctl_ready_i) begin
                ctl_valid_o <= 1'b0;
            end
            if (accept) begin
                ctl_q <= dec;
            end
        end
    end

    assign reg_dst_ctl_o    = ctl_q.reg_dst;
    assign jump_ctl_o       = ctl_q.jump;
    assign branch_ctl_o     = ctl_q.branch;
    assign mem_read_ctl_o   = ctl_q.mem_read;
    assign mem_to_reg_ctl_o = ctl_q.mem_to_reg;
    assign alu_op_ctl_o     = ctl_q.alu_op;
    assign mem_wr_ctl_o     = ctl_q.mem_wr;
    assign alu_src_ctl_o    = ctl_q.alu_src;
    assign reg_wr_ctl_o     = ctl_q.reg_wr;
    assign link_ctl_o       = ctl_q.link;
    assign illegal_ctl_o    = ctl_q.illegal;

endmodule

// File: tb/tb_decode_ctl.sv
// tb_decode_ctl: directed plus randomized check of decode_ctl against a table-driven reference model.
// Honours DECODE_ALU_EXT_EN for the SLT/SLTU/LUI ALU codes.
module tb_decode_ctl;

    localparam int LAT = 4;

    localparam logic [13:0] RD  = 14'h2000;
    localparam logic [13:0] JP  = 14'h1000;
    localparam logic [13:0] BR  = 14'h0800;
    localparam logic [13:0] MR  = 14'h0400;
    localparam logic [13:0] M2R = 14'h0200;
    localparam logic [13:0] MW  = 14'h0010;
    localparam logic [13:0] AS  = 14'h0008;
    localparam logic [13:0] RW  = 14'h0004;
    localparam logic [13:0] LK  = 14'h0002;
    localparam logic [13:0] IL  = 14'h0001;

`ifdef DECODE_ALU_EXT_EN
    localparam logic [3:0] EXP_SLT = 4'd9, EXP_SLTU = 4'd10, EXP_LUI = 4'd11;
`else
    localparam logic [3:0] EXP_SLT = 4'd1, EXP_SLTU = 4'd1, EXP_LUI = 4'd0;
`endif

    localparam logic [31:0] I_LW    = 32'h8C820004;
    localparam logic [31:0] I_MULT  = 32'h00850018;
    localparam logic [31:0] I_MFLO  = 32'h00001012;
    localparam logic [31:0] I_ADDI  = 32'h20420005;
    localparam logic [31:0] I_BEQ   = 32'h10220003;
    localparam logic [31:0] I_SLTU  = 32'h0022182B;
    localparam logic [31:0] I_LUI   = 32'h3C010005;

    logic        clk, rst;
    logic        instr_valid_i, instr_ready_o, flush_i, ctl_valid_o, ctl_ready_i;
    logic [31:0] instr_i;
    logic        reg_dst_ctl_o, jump_ctl_o, branch_ctl_o, mem_read_ctl_o, mem_to_reg_ctl_o;
    logic [3:0]  alu_op_ctl_o;
    logic        mem_wr_ctl_o, alu_src_ctl_o, reg_wr_ctl_o, link_ctl_o, illegal_ctl_o;
    logic        muldiv_start_o, hilo_busy_o;
    logic [13:0] obs_bundle;

    decode_ctl #(.MULDIV_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .instr_valid_i(instr_valid_i), .instr_i(instr_i), .instr_ready_o(instr_ready_o),
        .flush_i(flush_i), .ctl_valid_o(ctl_valid_o), .ctl_ready_i(ctl_ready_i),
        .reg_dst_ctl_o(reg_dst_ctl_o), .jump_ctl_o(jump_ctl_o), .branch_ctl_o(branch_ctl_o),
        .mem_read_ctl_o(mem_read_ctl_o), .mem_to_reg_ctl_o(mem_to_reg_ctl_o),
        .alu_op_ctl_o(alu_op_ctl_o), .mem_wr_ctl_o(mem_wr_ctl_o), .alu_src_ctl_o(alu_src_ctl_o),
        .reg_wr_ctl_o(reg_wr_ctl_o), .link_ctl_o(link_ctl_o), .illegal_ctl_o(illegal_ctl_o),
        .muldiv_start_o(muldiv_start_o), .hilo_busy_o(hilo_busy_o)
    );

    assign obs_bundle = {reg_dst_ctl_o, jump_ctl_o, branch_ctl_o, mem_read_ctl_o, mem_to_reg_ctl_o,
                         alu_op_ctl_o, mem_wr_ctl_o, alu_src_ctl_o, reg_wr_ctl_o, link_ctl_o,
                         illegal_ctl_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total, bad, e, busy_until, starts, n_mult, guard;
    bit          m_valid, m_start, last_acc;
    logic [13:0] m_bundle;
    logic [13:0] rtab [int];
    logic [13:0] itab [int];
    logic [13:0] btab [int];
    int          hilo_fns [$];
    logic [31:0] pool [$];

    function automatic logic [13:0] alu(input logic [3:0] a);
        return {5'b0, a, 5'b0};
    endfunction

    // Expected bundles are listed per mnemonic as flag sets; anything absent from a table is illegal.
    task automatic build_tables();
        rtab['h00] = RD | RW | alu(4'd2);  rtab['h04] = RD | RW | alu(4'd2);
        rtab['h02] = RD | RW | alu(4'd3);  rtab['h06] = RD | RW | alu(4'd3);
        rtab['h03] = RD | RW | alu(4'd4);  rtab['h07] = RD | RW | alu(4'd4);
        rtab['h20] = RD | RW;              rtab['h21] = RD | RW;
        rtab['h22] = RD | RW | alu(4'd1);  rtab['h23] = RD | RW | alu(4'd1);
        rtab['h24] = RD | RW | alu(4'd6);  rtab['h25] = RD | RW | alu(4'd5);
        rtab['h26] = RD | RW | alu(4'd8);  rtab['h27] = RD | RW | alu(4'd7);
        rtab['h2A] = RD | RW | alu(EXP_SLT);
        rtab['h2B] = RD | RW | alu(EXP_SLTU);
        rtab['h10] = RD | RW;              rtab['h12] = RD | RW;
        rtab['h11] = '0; rtab['h13] = '0; rtab['h18] = '0; rtab['h19] = '0;
        rtab['h1A] = '0; rtab['h1B] = '0; rtab['h0C] = '0;
        rtab['h08] = JP;
        rtab['h09] = JP | RD | RW | LK;
        itab['h02] = JP;
        itab['h03] = JP | RW | LK;
        for (int k = 4; k <= 7; k++) itab[k] = BR | alu(4'd1);
        itab['h08] = AS | RW;              itab['h09] = AS | RW;
        itab['h0A] = AS | RW | alu(EXP_SLT);
        itab['h0B] = AS | RW | alu(EXP_SLTU);
        itab['h0C] = AS | RW | alu(4'd6);  itab['h0D] = AS | RW | alu(4'd5);
        itab['h0E] = AS | RW | alu(4'd8);  itab['h0F] = AS | RW | alu(EXP_LUI);
        foreach (pool[k]) begin end
        itab['h20] = AS | MR | M2R | RW;   itab['h21] = AS | MR | M2R | RW;
        itab['h23] = AS | MR | M2R | RW;   itab['h24] = AS | MR | M2R | RW;
        itab['h25] = AS | MR | M2R | RW;
        itab['h28] = AS | MW;  itab['h29] = AS | MW;  itab['h2B] = AS | MW;
        btab['h00] = BR | alu(4'd1);       btab['h01] = BR | alu(4'd1);
        btab['h10] = BR | alu(4'd1) | RW | LK;
        btab['h11] = BR | alu(4'd1) | RW | LK;
        hilo_fns = '{'h10, 'h11, 'h12, 'h13, 'h18, 'h19, 'h1A, 'h1B};
        pool = '{32'h8C820004, 32'hAC820004, 32'h80820000, 32'h90820000, 32'h84820000,
                 32'h94820000, 32'hA0820000, 32'hA4820000, 32'h20420005, 32'h24420005,
                 32'h28420005, 32'h2C420005, 32'h30420005, 32'h34420005, 32'h38420005,
                 32'h3C010005, 32'h10220003, 32'h14220003, 32'h18200003, 32'h1C200003,
                 32'h08000010, 32'h0C000010, 32'h04200003, 32'h04210003, 32'h04300003,
                 32'h04310003, 32'h00221820, 32'h00221822, 32'h00221824, 32'h00221825,
                 32'h00221826, 32'h00221827, 32'h0022182A, 32'h0022182B, 32'h00021080,
                 32'h00021082, 32'h00021083, 32'h00221804, 32'h03E00008, 32'h0040F809,
                 32'h0000000C, 32'h00001010, 32'h00001012, 32'h00200011, 32'h00200013,
                 32'h00850018, 32'h00850019, 32'h0085001A, 32'h0085001B};
    endtask

    function automatic logic [13:0] model(input logic [31:0] w);
        int op, rt, fn;
        op = int'(w[31:26]);
        rt = int'(w[20:16]);
        fn = int'(w[5:0]);
        if (op == 0) return rtab.exists(fn) ? rtab[fn] : IL;
        if (op == 1) return btab.exists(rt) ? btab[rt] : IL;
        return itab.exists(op) ? itab[op] : IL;
    endfunction

    function automatic bit is_hilo(input logic [31:0] w);
        bit hit;
        hit = 1'b0;
        foreach (hilo_fns[k]) if (int'(w[5:0]) == hilo_fns[k]) hit = 1'b1;
        return (w[31:26] == 6'd0) && hit;
    endfunction

    function automatic bit is_muldiv(input logic [31:0] w);
        return (w[31:26] == 6'd0) && (int'(w[5:0]) >= 'h18) && (int'(w[5:0]) <= 'h1B);
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic v, input logic [31:0] w, input logic rdy,
                                  input logic fl);
        instr_valid_i = v;
        instr_i       = w;
        ctl_ready_i   = rdy;
        flush_i       = fl;
    endtask

    // One clock: check the handshake against the model, step the model, check the registered outputs.
    task automatic tick();
        bit          rdy, acc, rst_edge, busy_exp;
        logic [31:0] w;
        #1;
        w        = instr_i;
        rst_edge = rst;
        busy_exp = (e + 1 < busy_until);
        rdy      = !flush_i && !(is_hilo(w) && busy_exp) && (!m_valid || ctl_ready_i);
        if (!rst_edge) begin
            check_output("ready", 32'(instr_ready_o), 32'(rdy));
            check_output("hilo_busy", 32'(hilo_busy_o), 32'(busy_exp));
        end
        acc = instr_valid_i && rdy && !rst_edge;
        @(posedge clk);
        #1;
        e++;
        if (rst_edge) begin
            m_valid    = 1'b0;
            m_start    = 1'b0;
            m_bundle   = '0;
            busy_until = 0;
        end else begin
            m_start = acc && is_muldiv(w);
            if (m_start) busy_until = e + LAT;
            if (flush_i) m_valid = 1'b0;
            else if (acc) begin
                m_valid  = 1'b1;
                m_bundle = model(w);
            end else if (ctl_ready_i) m_valid = 1'b0;
        end
        if (muldiv_start_o === 1'b1) starts++;
        last_acc = acc;
        check_output("ctl_valid", 32'(ctl_valid_o), 32'(m_valid));
        check_output("muldiv_start", 32'(muldiv_start_o), 32'(m_start));
        if (m_valid || rst_edge) check_output("bundle", 32'(obs_bundle), 32'(m_bundle));
    endtask

    initial begin
        logic [31:0] w;
        total = 0; bad = 0; e = 0; busy_until = 0; starts = 0;
        m_valid = 1'b0; m_start = 1'b0; last_acc = 1'b0; m_bundle = '0;
        build_tables();

        rst = 1'b1;
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        tick();
        check_output("rst_valid", 32'(ctl_valid_o), 32'd0);
        check_output("rst_bundle", 32'(obs_bundle), 32'd0);
        check_output("rst_busy", 32'(hilo_busy_o), 32'd0);
        rst = 1'b0;

        apply_stimulus(1'b1, I_LW, 1'b1, 1'b0);
        tick();
        check_output("lw_valid", 32'(ctl_valid_o), 32'd1);
        check_output("lw_bundle", 32'(obs_bundle), 32'(AS | MR | M2R | RW));
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        check_output("drain_valid", 32'(ctl_valid_o), 32'd0);

        starts = 0;
        apply_stimulus(1'b1, I_MULT, 1'b1, 1'b0);
        tick();
        n_mult = e;
        apply_stimulus(1'b1, I_MFLO, 1'b1, 1'b0);
        guard = 0;
        do begin
            tick();
            guard++;
        end while (!last_acc && guard < 20);
        check_output("mflo_accept_edge", 32'(e - n_mult), 32'(LAT));
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
        repeat (6) tick();
        check_output("start_pulses", 32'(starts), 32'd1);

        apply_stimulus(1'b1, I_ADDI, 1'b1, 1'b0);
        tick();
        apply_stimulus(1'b1, I_BEQ, 1'b0, 1'b0);
        repeat (3) begin
            tick();
            check_output("addi_hold", 32'(obs_bundle), 32'(AS | RW));
            check_output("beq_blocked", 32'(instr_ready_o), 32'd0);
        end
        apply_stimulus(1'b1, I_BEQ, 1'b1, 1'b0);
        tick();
        check_output("beq_branch", 32'(branch_ctl_o), 32'd1);
        check_output("beq_alu", 32'(alu_op_ctl_o), 32'd1);
        check_output("beq_mem_read", 32'(mem_read_ctl_o), 32'd0);

        apply_stimulus(1'b1, 32'h0000003F, 1'b1, 1'b0);
        tick();
        check_output("bad_funct", 32'(obs_bundle), 32'(IL));
        apply_stimulus(1'b1, 32'h04420000, 1'b1, 1'b0);
        tick();
        check_output("bad_rt_illegal", 32'(illegal_ctl_o), 32'd1);
        check_output("bad_rt_writes", 32'({reg_wr_ctl_o, mem_wr_ctl_o}), 32'd0);
        apply_stimulus(1'b1, 32'h20220020, 1'b1, 1'b0);
        tick();
        check_output("addi_funct_ignored", 32'(obs_bundle), 32'(AS | RW));

        apply_stimulus(1'b1, I_ADDI, 1'b1, 1'b0);
        tick();
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b1, I_BEQ, 1'b1, 1'b1);
        tick();
        check_output("flush_valid", 32'(ctl_valid_o), 32'd0);

        apply_stimulus(1'b1, I_MULT, 1'b1, 1'b0);
        tick();
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        check_output("busy_window", 32'(hilo_busy_o), 32'd1);
        rst = 1'b1;
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b1);
        tick();
        rst = 1'b0;
        check_output("busy_after_rst", 32'(hilo_busy_o), 32'd0);

        apply_stimulus(1'b1, I_SLTU, 1'b1, 1'b0);
        tick();
        check_output("sltu_alu", 32'(alu_op_ctl_o), 32'(EXP_SLTU));
        apply_stimulus(1'b1, I_LUI, 1'b1, 1'b0);
        tick();
        check_output("lui_alu", 32'(alu_op_ctl_o), 32'(EXP_LUI));
        check_output("lui_mem_read", 32'(mem_read_ctl_o), 32'd0);

        repeat (400) begin
            if ($urandom_range(0, 4) == 0) begin
                w = $urandom;
            end else begin
                w = pool[$urandom_range(0, pool.size() - 1)];
                w[25:21] = 5'($urandom);
                w[15:6]  = 10'($urandom);
                if (w[31:26] != 6'd1) w[20:16] = 5'($urandom);
            end
            apply_stimulus(1'($urandom_range(0, 3) != 0), w, 1'($urandom_range(0, 2) != 0),
                           1'($urandom_range(0, 15) == 0));
            tick();
        end
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
        repeat (8) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
